// File: rtl/trivium_stream_if.sv
// Keystream port bundle: key/IV load request in, W-bit keystream words out
// over a valid/ready handshake. The generator uses the master view; the
// consumer/key-management side uses the slave view.
interface trivium_stream_if #(
  parameter int W = 1
) ();
  logic          load;
  logic [79:0]   key_i;
  logic [79:0]   iv_i;
  logic [W-1:0]  ks_data;
  logic          ks_valid;
  logic          ks_ready;
  logic          busy;

  modport master (
    input  load, key_i, iv_i, ks_ready,
    output ks_data, ks_valid, busy
  );

  modport slave (
    output load, key_i, iv_i, ks_ready,
    input  ks_data, ks_valid, busy
  );
endinterface

// File: rtl/trivium_stream.sv
// Trivium keystream generator, W cipher steps per clock.
// Key/IV are loaded at runtime; after INIT_ROUNDS discarded warm-up steps the
// core emits W-bit keystream words (bit 0 = earliest bit) with backpressure.
module trivium_stream #(
  parameter int W           = 1,
  parameter int INIT_ROUNDS = 1152
) (
  input  logic             clk,
  input  logic             rst,
  trivium_stream_if.master ks
);
  localparam int CW = $clog2(INIT_ROUNDS) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(INIT_ROUNDS - W);
  localparam logic [CW-1:0] CNT_STEP = CW'(W);

  if (W < 1 || W > 64) begin : g_bad_w
    $error("trivium_stream: W must be in 1..64");
  end
  if (INIT_ROUNDS <= 0 || (W >= 1 && (INIT_ROUNDS % W) != 0)) begin : g_bad_rounds
    $error("trivium_stream: INIT_ROUNDS must be a nonzero multiple of W");
  end

  typedef enum logic [1:0] {
    IDLE,
    INIT,
    RUN
  } state_t;

  state_t        state;
  state_t        state_nxt;
  logic [287:0]  s;
  logic [287:0]  s_nxt;
  logic [287:0]  s_load;
  logic [CW-1:0] cnt;
  logic [W-1:0]  z_word;
  logic [W-1:0]  ks_data_q;
  logic          ks_valid_q;
  logic          adv;
  logic          emit;
  logic          t1, t2, t3;
  logic          n1, n2, n3;

  // A = key, zero pad; B = IV, zero pad; C = zeros with the three top-of-C ones.
  assign s_load = {ks.key_i, 13'b0, ks.iv_i, 4'b0, 108'b0, 3'b111};

  assign ks.ks_data  = ks_data_q;
  assign ks.ks_valid = ks_valid_q;
  assign ks.busy     = (state == INIT);

  // W sequential cipher steps unrolled into one combinational update.
  always_comb begin
    s_nxt  = s;
    z_word = '0;
    t1 = 1'b0; t2 = 1'b0; t3 = 1'b0;
    n1 = 1'b0; n2 = 1'b0; n3 = 1'b0;
    for (int unsigned k = 0; k < W; k++) begin
      t1 = s_nxt[222] ^ s_nxt[195];
      t2 = s_nxt[126] ^ s_nxt[111];
      t3 = s_nxt[45]  ^ s_nxt[0];
      z_word[k] = t1 ^ t2 ^ t3;
      n1 = t1 ^ (s_nxt[196] & s_nxt[197]) ^ s_nxt[117];
      n2 = t2 ^ (s_nxt[112] & s_nxt[113]) ^ s_nxt[24];
      n3 = t3 ^ (s_nxt[1]   & s_nxt[2])   ^ s_nxt[219];
      s_nxt = {n3, s_nxt[287:196], n1, s_nxt[194:112], n2, s_nxt[110:1]};
    end
  end

  // State register; reset dominates load.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state and step/emit decisions; load restarts from any state.
  always_comb begin
    state_nxt = state;
    adv       = 1'b0;
    emit      = 1'b0;
    unique case (state)
      IDLE: begin
        if (ks.load) state_nxt = INIT;
      end
      INIT: begin
        adv = 1'b1;
        if (cnt == CNT_LAST) state_nxt = RUN;
      end
      RUN: begin
        adv  = !ks_valid_q || ks.ks_ready;
        emit = adv;
      end
      default: state_nxt = IDLE;
    endcase
    if (ks.load) state_nxt = INIT;
  end

  // Cipher state, warm-up counter and output word register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s          <= '0;
      cnt        <= '0;
      ks_valid_q <= 1'b0;
      ks_data_q  <= '0;
    end else if (ks.load) begin
      // A pending word is dropped even if ks_ready is high on this edge.
      s          <= s_load;
      cnt        <= '0;
      ks_valid_q <= 1'b0;
    end else begin
      if (adv) s <= s_nxt;
      if (state == INIT) cnt <= cnt + CNT_STEP;
      if (emit) begin
        ks_data_q  <= z_word;
        ks_valid_q <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_trivium_stream.sv
// Bench for trivium_stream: three instances (W = 1, 8, 64) share key/IV/load;
// a reference Trivium model in standard 1..288 indexing predicts every output.
module tb_trivium_stream;
  localparam logic [79:0] KEY = 80'h9719CFC92A9FF688F9AA;
  localparam logic [79:0] IV  = 80'hECBB76B09AFF71D0D151;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic load = 1'b0;
  logic [79:0] key = '0;
  logic [79:0] iv  = '0;
  logic rdy [3];

  always #5 clk = ~clk;

  trivium_stream_if #(.W(1))  if1 ();
  trivium_stream_if #(.W(8))  if8 ();
  trivium_stream_if #(.W(64)) if64 ();

  trivium_stream #(.W(1),  .INIT_ROUNDS(1152)) u_w1  (.clk(clk), .rst(rst), .ks(if1));
  trivium_stream #(.W(8),  .INIT_ROUNDS(1152)) u_w8  (.clk(clk), .rst(rst), .ks(if8));
  trivium_stream #(.W(64), .INIT_ROUNDS(1152)) u_w64 (.clk(clk), .rst(rst), .ks(if64));

  assign if1.load = load;  assign if1.key_i = key;  assign if1.iv_i = iv;  assign if1.ks_ready = rdy[0];
  assign if8.load = load;  assign if8.key_i = key;  assign if8.iv_i = iv;  assign if8.ks_ready = rdy[1];
  assign if64.load = load; assign if64.key_i = key; assign if64.iv_i = iv; assign if64.ks_ready = rdy[2];

  logic [63:0] dat [3];
  logic        vld [3];
  logic        bsy [3];
  assign dat[0] = 64'(if1.ks_data);  assign vld[0] = if1.ks_valid;  assign bsy[0] = if1.busy;
  assign dat[1] = 64'(if8.ks_data);  assign vld[1] = if8.ks_valid;  assign bsy[1] = if8.busy;
  assign dat[2] = if64.ks_data;      assign vld[2] = if64.ks_valid; assign bsy[2] = if64.busy;

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input int lane, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s lane%0d: got %0h expected %0h", name, lane, act, exp);
    end
  endtask

  function automatic int lw(input int l);
    return (l == 0) ? 1 : ((l == 1) ? 8 : 64);
  endfunction

  // Standard Trivium: st[i] is s_i of the published description.
  function automatic logic [288:1] ld(input logic [79:0] k, input logic [79:0] v);
    logic [288:1] st;
    st = '0;
    for (int i = 1; i <= 80; i++) begin
      st[i]      = k[80-i];
      st[93 + i] = v[80-i];
    end
    st[286] = 1'b1; st[287] = 1'b1; st[288] = 1'b1;
    return st;
  endfunction

  // Returns {next state, z}.
  function automatic logic [288:0] tv_step(input logic [288:1] st);
    logic t1, t2, t3, z;
    logic [288:1] ns;
    t1 = st[66]  ^ st[93];
    t2 = st[162] ^ st[177];
    t3 = st[243] ^ st[288];
    z  = t1 ^ t2 ^ t3;
    t1 = t1 ^ (st[91]  & st[92])  ^ st[171];
    t2 = t2 ^ (st[175] & st[176]) ^ st[264];
    t3 = t3 ^ (st[286] & st[287]) ^ st[69];
    ns = st << 1;
    ns[1] = t3; ns[94] = t1; ns[178] = t2;
    return {ns, z};
  endfunction

  // Model state per lane.
  logic [288:1] mst [3];
  logic         m_act [3];
  logic         m_valid [3];
  logic         m_busy [3];
  logic [63:0]  m_data [3];
  int           m_age [3];
  int           cyc = 0;
  int           load_cyc [3];
  int           first_v [3];
  int           busy_n [3];
  logic         cap_en = 1'b0;
  logic [4095:0] cap [3];
  int           cap_n [3];
  int           stalls = 0;

  // Compare outputs to the model on every falling edge, then advance the
  // model with the inputs the next rising edge will sample.
  initial begin
    logic [288:0] r;
    logic [288:1] w;
    for (int l = 0; l < 3; l++) begin
      m_act[l] = 1'b0; m_valid[l] = 1'b0; m_busy[l] = 1'b0; m_data[l] = '0;
      m_age[l] = 0; first_v[l] = -1; busy_n[l] = 0; cap_n[l] = 0; cap[l] = '0;
      load_cyc[l] = 0;
    end
    forever begin
      @(negedge clk);
      for (int l = 0; l < 3; l++) begin
        chk("valid", l, 64'(vld[l]), 64'(m_valid[l]));
        chk("busy",  l, 64'(bsy[l]), 64'(m_busy[l]));
        if (m_valid[l] || !m_act[l]) chk("data", l, dat[l], m_data[l]);
        if (bsy[l]) busy_n[l]++;
        if (vld[l] && first_v[l] < 0 && m_act[l]) first_v[l] = cyc - load_cyc[l];
        if (l == 1 && vld[l] && !rdy[l]) stalls++;
        if (cap_en && vld[l] && rdy[l] && !load && !rst)
          for (int k = 0; k < lw(l); k++)
            if (cap_n[l] < 4096) begin
              cap[l][cap_n[l]] = dat[l][k];
              cap_n[l]++;
            end
      end
      cyc++;
      if (load && !rst) begin
        w = ld(key, iv);
        repeat (1152) begin
          r = tv_step(w);
          w = r[288:1];
        end
      end
      for (int l = 0; l < 3; l++) begin
        if (rst) begin
          m_act[l] = 1'b0; m_valid[l] = 1'b0; m_busy[l] = 1'b0; m_data[l] = '0;
        end else if (load) begin
          mst[l] = w; m_act[l] = 1'b1; m_age[l] = 0; m_busy[l] = 1'b1; m_valid[l] = 1'b0;
          load_cyc[l] = cyc; first_v[l] = -1; busy_n[l] = 0;
        end else if (m_act[l]) begin
          m_age[l]++;
          m_busy[l] = (m_age[l] < 1152 / lw(l));
          if (m_age[l] > 1152 / lw(l) && (!m_valid[l] || rdy[l])) begin
            m_data[l] = '0;
            for (int k = 0; k < lw(l); k++) begin
              r = tv_step(mst[l]);
              mst[l] = r[288:1];
              m_data[l][k] = r[0];
            end
            m_valid[l] = 1'b1;
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_load();
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic check_latency();
    int exp_lat [3];
    int exp_busy [3];
    exp_lat  = '{1153, 145, 19};
    exp_busy = '{1152, 144, 18};
    for (int l = 0; l < 3; l++) begin
      chk("first_valid_latency", l, 64'(first_v[l]), 64'(exp_lat[l]));
      chk("busy_cycles", l, 64'(busy_n[l]), 64'(exp_busy[l]));
    end
  endtask

  initial begin
    logic [288:0] r;
    logic [288:1] st;
    logic [3:0]   zz;
    logic [79:0]  kv;
    int           mism;

    rdy[0] = 1'b1; rdy[1] = 1'b1; rdy[2] = 1'b1;

    // Hand-derived pins for the model: zero key/IV starts 1,1,1,0;
    // key_i[14] (s66) and iv_i[11] (s162) each cancel the first bit.
    st = ld('0, '0);
    for (int i = 0; i < 4; i++) begin
      r = tv_step(st);
      st = r[288:1];
      zz[i] = r[0];
    end
    chk("model_zero_first4", 0, 64'(zz), 64'h7);
    kv = 80'd1 << 14;
    r = tv_step(ld(kv, '0));
    chk("model_key_bit14", 0, 64'(r[0]), 64'h0);
    kv = 80'd1 << 11;
    r = tv_step(ld('0, kv));
    chk("model_iv_bit11", 0, 64'(r[0]), 64'h0);

    // Reset, then idle with no load.
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    for (int l = 0; l < 3; l++) begin
      chk("idle_valid", l, 64'(vld[l]), 64'h0);
      chk("idle_busy",  l, 64'(bsy[l]), 64'h0);
      chk("idle_data",  l, dat[l], 64'h0);
    end

    // Golden key/IV on all widths, consumer always ready.
    key = KEY; iv = IV;
    cap_en = 1'b1;
    pulse_load();
    repeat (1153 + 4096 + 10) tick();
    cap_en = 1'b0;
    check_latency();
    for (int l = 0; l < 3; l++) chk("captured_bits", l, 64'(cap_n[l]), 64'd4096);
    for (int l = 1; l < 3; l++) begin
      mism = 0;
      for (int i = 0; i < 4096; i++) if (cap[l][i] !== cap[0][i]) mism++;
      chk("stream_vs_w1", l, 64'(mism), 64'h0);
    end

    // Random backpressure on the W=8 instance.
    repeat (800) begin
      rdy[1] = ($urandom_range(0, 9) < 3);
      tick();
    end
    rdy[1] = 1'b1;
    chk("stalls_exercised", 1, 64'(stalls > 0), 64'h1);
    tick();

    // Reload mid-RUN with a zero IV while ready is high on the load edge.
    iv = '0;
    pulse_load();
    for (int l = 0; l < 3; l++) begin
      chk("reload_valid_clear", l, 64'(vld[l]), 64'h0);
      chk("reload_busy", l, 64'(bsy[l]), 64'h1);
    end
    repeat (1153 + 200) tick();
    check_latency();

    // Reset 500 cycles into warm-up, then a fresh load.
    iv = IV;
    pulse_load();
    repeat (499) tick();
    rst = 1'b1;
    tick();
    for (int l = 0; l < 3; l++) begin
      chk("rst_mid_init_valid", l, 64'(vld[l]), 64'h0);
      chk("rst_mid_init_busy",  l, 64'(bsy[l]), 64'h0);
      chk("rst_mid_init_data",  l, dat[l], 64'h0);
    end
    rst = 1'b0;
    repeat (10) tick();
    pulse_load();
    repeat (1153 + 300) tick();
    check_latency();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
